// File: rtl/ex_ctrl_flags_reg.sv
`default_nettype none
// ============================================================================
//  Module      : ex_ctrl_flags_reg
//  Description : Decode->Execute control pipeline register plus the
//                architectural NZCV flags register. Stall holds both
//                registers; flush loads a bubble into the control register
//                only. The flags register closes the loop through the
//                E-stage condition logic (FlagsE out, FlagsD back in).
//  Options     : `define BUBBLE_CNT_EN adds a saturating bubble counter on
//                the BubbleCnt port.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_ctrl_flags_reg #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             StallE,
  input  logic             FlushE,
  input  logic [3:0]       CondD,
  input  logic [1:0]       FlagWriteD,
  input  logic             PCSrcD,
  input  logic             RegWriteD,
  input  logic             MemWriteD,
  input  logic             BranchD,
  input  logic [3:0]       FlagsD,
  output logic [3:0]       CondE,
  output logic [1:0]       FlagWriteE,
  output logic             PCSrcE,
  output logic             RegWriteE,
  output logic             MemWriteE,
  output logic             BranchE,
  output logic             ValidE,
  output logic [3:0]       FlagsE
`ifdef BUBBLE_CNT_EN
  ,
  output logic [CNT_W-1:0] BubbleCnt
`endif
);

  // A bubble uses AL rather than the reserved 1111 encoding so that the
  // downstream condition check always sees a defined condition.
  localparam logic [3:0] C_COND_BUBBLE = 4'b1110;

  logic [3:0] cond_q,      cond_d;
  logic [1:0] flagwrite_q, flagwrite_d;
  logic       pcsrc_q,     pcsrc_d;
  logic       regwrite_q,  regwrite_d;
  logic       memwrite_q,  memwrite_d;
  logic       branch_q,    branch_d;
  logic       valid_q,     valid_d;
  logic [3:0] flags_q,     flags_d;

  // Control next-state: flush (bubble) beats stall (hold) beats load.
  always_comb begin
    cond_d      = cond_q;
    flagwrite_d = flagwrite_q;
    pcsrc_d     = pcsrc_q;
    regwrite_d  = regwrite_q;
    memwrite_d  = memwrite_q;
    branch_d    = branch_q;
    valid_d     = valid_q;
    if (FlushE) begin
      cond_d      = C_COND_BUBBLE;
      flagwrite_d = 2'b00;
      pcsrc_d     = 1'b0;
      regwrite_d  = 1'b0;
      memwrite_d  = 1'b0;
      branch_d    = 1'b0;
      valid_d     = 1'b0;
    end else if (!StallE) begin
      cond_d      = CondD;
      flagwrite_d = FlagWriteD;
      pcsrc_d     = PCSrcD;
      regwrite_d  = RegWriteD;
      memwrite_d  = MemWriteD;
      branch_d    = BranchD;
      valid_d     = 1'b1;
    end
  end

  // Flags next-state: only a stall holds; the instruction leaving E on a
  // flush still commits its flags. A bubble has FlagWriteE=0 so the
  // condition logic returns FlagsD==FlagsE and nothing changes.
  always_comb begin
    flags_d = flags_q;
    if (!StallE) begin
      flags_d = FlagsD;
    end
  end

  // Control pipeline register with asynchronous reset to the bubble state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cond_q      <= C_COND_BUBBLE;
      flagwrite_q <= 2'b00;
      pcsrc_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      branch_q    <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      cond_q      <= cond_d;
      flagwrite_q <= flagwrite_d;
      pcsrc_q     <= pcsrc_d;
      regwrite_q  <= regwrite_d;
      memwrite_q  <= memwrite_d;
      branch_q    <= branch_d;
      valid_q     <= valid_d;
    end
  end

  // Architectural NZCV register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= RESET_FLAGS;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign CondE      = cond_q;
  assign FlagWriteE = flagwrite_q;
  assign PCSrcE     = pcsrc_q;
  assign RegWriteE  = regwrite_q;
  assign MemWriteE  = memwrite_q;
  assign BranchE    = branch_q;
  assign ValidE     = valid_q;
  assign FlagsE     = flags_q;

`ifdef BUBBLE_CNT_EN
  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Count flush edges regardless of stall, sticking at the maximum value.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (FlushE && (bubble_cnt_q != C_CNT_MAX)) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  // Bubble counter register; only reset clears it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bubble_cnt_q <= '0;
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign BubbleCnt = bubble_cnt_q;
`else
  // CNT_W only sizes the bubble counter; this tie-off keeps the parameter
  // referenced when the counter is not built.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
`default_nettype wire
